tcdm_tag_shadow_bridge: RTL and testbench

TCDM_TAG_SHADOW_BRIDGE -- requirements
Module: tcdm_tag_shadow_bridge

---
 rtl/tcdm_tag_shadow_bridge.sv | 132 +++++++++++++
 tb/tb_tcdm_tag_shadow_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_tag_shadow_bridge.sv
// TCDM pass-through bridge that keeps one shadow tag bit per byte lane for a
// window of words and returns the tags alongside read responses.
module tcdm_tag_shadow_bridge #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TAG_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned TAG_DEPTH       = 1024,
    parameter logic [31:0] ADDR_BASE       = 32'h1C00_0000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic        TAG_DEFAULT     = 1'b1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       tag_clear_i,
    output logic                                       err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
    input  logic                                       s_req_i,
    input  logic [31:0]                                s_add_i,
    input  logic                                       s_wen_i,
    input  logic [TAG_WIDTH-1:0]                       s_be_i,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0]            s_wdata_i,
    output logic                                       s_gnt_o,
    output logic                                       s_r_valid_o,
    output logic                                       s_r_opc_o,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0]            s_r_rdata_o,
    output logic                                       m_req_o,
    output logic [31:0]                                m_add_o,
    output logic                                       m_wen_o,
    output logic [TAG_WIDTH-1:0]                       m_be_o,
    output logic [DATA_WIDTH-1:0]                      m_wdata_o,
    input  logic                                       m_gnt_i,
    input  logic                                       m_r_valid_i,
    input  logic                                       m_r_opc_i,
    input  logic [DATA_WIDTH-1:0]                      m_r_rdata_i
);

    localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDXW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TAG_WIDTH-1:0] TAG_DEF  = {TAG_WIDTH{TAG_DEFAULT}};
    localparam logic [CNTW-1:0]      CNT_MAX  = CNTW'(MAX_OUTSTANDING);
    localparam logic [PTRW-1:0]      PTR_LAST = PTRW'(MAX_OUTSTANDING - 1);

    logic [TAG_WIDTH-1:0] r_tags [TAG_DEPTH];
    logic [TAG_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTRW-1:0]      r_wptr;
    logic [PTRW-1:0]      r_rptr;
    logic [CNTW-1:0]      r_count;
    logic                 r_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_pop;
    logic [31:0]          w_off;
    logic [31:0]          w_word;
    logic                 w_covered;
    logic [IDXW-1:0]      w_idx;
    logic [TAG_WIDTH-1:0] w_cur_tag;
    logic [TAG_WIDTH-1:0] w_wtag;
    logic [TAG_WIDTH-1:0] w_merged;
    logic [TAG_WIDTH-1:0] w_push_tag;
    logic [TAG_WIDTH-1:0] w_resp_tag;

    assign w_full   = (r_count == CNT_MAX);
    assign w_empty  = (r_count == '0);
    assign w_accept = s_req_i & s_gnt_o;
    assign w_pop    = m_r_valid_i & ~w_empty;

    assign m_req_o   = s_req_i & ~w_full;
    assign s_gnt_o   = m_gnt_i & ~w_full;
    assign m_add_o   = s_add_i;
    assign m_wen_o   = s_wen_i;
    assign m_be_o    = s_be_i;
    assign m_wdata_o = s_wdata_i[DATA_WIDTH-1:0];

    assign w_off     = s_add_i - ADDR_BASE;
    assign w_word    = w_off >> OFFS;
    assign w_covered = (s_add_i >= ADDR_BASE) && (w_word < 32'(TAG_DEPTH));
    assign w_idx     = w_word[IDXW-1:0];
    assign w_cur_tag = w_covered ? r_tags[w_idx] : TAG_DEF;
    assign w_wtag    = s_wdata_i[DATA_WIDTH +: TAG_WIDTH];
    assign w_merged  = (w_cur_tag & ~s_be_i) | (w_wtag & s_be_i);
    // Reads capture the pre-edge tag; writes carry only the default tag.
    assign w_push_tag = s_wen_i ? w_cur_tag : TAG_DEF;

    assign w_resp_tag  = w_empty ? TAG_DEF : r_fifo[r_rptr];
    assign s_r_valid_o = m_r_valid_i;
    assign s_r_opc_o   = m_r_opc_i;
    assign s_r_rdata_o = {w_resp_tag, m_r_rdata_i};

    assign err_o         = r_err;
    assign outstanding_o = r_count;

    // Clear takes priority over a write accepted in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tags <= '{default: TAG_DEF};
        end else if (tag_clear_i) begin
            r_tags <= '{default: TAG_DEF};
        end else if (w_accept && !s_wen_i && w_covered) begin
            r_tags[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo  <= '{default: '0};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (m_r_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_fifo[r_wptr] <= w_push_tag;
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTRW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_tcdm_tag_shadow_bridge.sv
// Bench for tcdm_tag_shadow_bridge: directed scenarios plus randomized traffic
// checked against a queue/array reference model, and a 64-bit instance.
module tb_tcdm_tag_shadow_bridge;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        tag_clear_i;
    logic        err_o;
    logic [1:0]  outstanding_o;
    logic        s_req_i;
    logic [31:0] s_add_i;
    logic        s_wen_i;
    logic [3:0]  s_be_i;
    logic [35:0] s_wdata_i;
    logic        s_gnt_o;
    logic        s_r_valid_o;
    logic        s_r_opc_o;
    logic [35:0] s_r_rdata_o;
    logic        m_req_o;
    logic [31:0] m_add_o;
    logic        m_wen_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_r_valid_i;
    logic        m_r_opc_i;
    logic [31:0] m_r_rdata_i;

    logic        d_clr;
    logic        d_err;
    logic [1:0]  d_out;
    logic        d_req;
    logic [31:0] d_add;
    logic        d_wen;
    logic [7:0]  d_be;
    logic [71:0] d_wdata;
    logic        d_s_gnt;
    logic        d_s_rv;
    logic        d_s_opc;
    logic [71:0] d_s_rdata;
    logic        d_m_req;
    logic [31:0] d_m_add;
    logic        d_m_wen;
    logic [7:0]  d_m_be;
    logic [63:0] d_m_wdata;
    logic        d_gnt;
    logic        d_rv;
    logic        d_opc;
    logic [63:0] d_rdata;

    tcdm_tag_shadow_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tag_clear_i(tag_clear_i),
        .err_o(err_o), .outstanding_o(outstanding_o),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_be_i(s_be_i),
        .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o),
        .s_r_opc_o(s_r_opc_o), .s_r_rdata_o(s_r_rdata_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_be_o(m_be_o),
        .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i),
        .m_r_opc_i(m_r_opc_i), .m_r_rdata_i(m_r_rdata_i)
    );

    tcdm_tag_shadow_bridge #(.DATA_WIDTH(64)) dut64 (
        .clk_i(clk_i), .rst_ni(rst_ni), .tag_clear_i(d_clr),
        .err_o(d_err), .outstanding_o(d_out),
        .s_req_i(d_req), .s_add_i(d_add), .s_wen_i(d_wen), .s_be_i(d_be),
        .s_wdata_i(d_wdata), .s_gnt_o(d_s_gnt), .s_r_valid_o(d_s_rv),
        .s_r_opc_o(d_s_opc), .s_r_rdata_o(d_s_rdata),
        .m_req_o(d_m_req), .m_add_o(d_m_add), .m_wen_o(d_m_wen), .m_be_o(d_m_be),
        .m_wdata_o(d_m_wdata), .m_gnt_i(d_gnt), .m_r_valid_i(d_rv),
        .m_r_opc_i(d_opc), .m_r_rdata_i(d_rdata)
    );

    always #5 clk_i = ~clk_i;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [3:0]  mtags [1024];
    logic [3:0]  mq [$];
    bit          merr;

    logic        snap_gnt;
    logic        snap_req;
    logic [35:0] snap_rdata;
    logic        snap64_gnt;
    logic [71:0] snap64;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) mtags[i] = 4'hF;
        mq.delete();
        merr = 1'b0;
    endtask

    task automatic model_map(input logic [31:0] a, output bit cov, output int idx);
        longint unsigned w;
        cov = 1'b0;
        idx = 0;
        if (a >= BASE) begin
            w = (longint'(a) - longint'(BASE)) / 4;
            cov = (w < 1024);
            idx = int'(w % 1024);
        end
    endtask

    task automatic drive(input bit req, input bit wen, input logic [31:0] addr,
                         input logic [3:0] be, input logic [3:0] tag,
                         input bit gnt, input bit rv, input bit clr);
        s_req_i     = req;
        s_wen_i     = wen;
        s_add_i     = addr;
        s_be_i      = be;
        s_wdata_i   = {tag, 32'($urandom())};
        m_gnt_i     = gnt;
        m_r_valid_i = rv;
        m_r_opc_i   = 1'($urandom_range(0, 1));
        m_r_rdata_i = $urandom();
        tag_clear_i = clr;
    endtask

    task automatic drive64(input bit req, input bit wen, input logic [31:0] addr,
                           input logic [7:0] be, input logic [7:0] tag,
                           input bit gnt, input bit rv, input logic [63:0] rd);
        d_req   = req;
        d_wen   = wen;
        d_add   = addr;
        d_be    = be;
        d_wdata = {tag, 64'hA5A5_5A5A_0123_4567};
        d_gnt   = gnt;
        d_rv    = rv;
        d_opc   = 1'b0;
        d_rdata = rd;
    endtask

    // One clock: check outputs against the model before the edge, then advance the model.
    task automatic cycle();
        bit         full, gnt, acc, cov;
        int         idx;
        logic [3:0] exp_tag, push_val;
        #1;
        chk("outstanding", outstanding_o, mq.size());
        chk("err", err_o, merr);
        full = (mq.size() >= 2);
        gnt  = m_gnt_i && !full;
        chk("s_gnt", s_gnt_o, gnt);
        chk("m_req", m_req_o, s_req_i && !full);
        chk("m_add", m_add_o, s_add_i);
        chk("m_wen", m_wen_o, s_wen_i);
        chk("m_be", m_be_o, s_be_i);
        chk("m_wdata", m_wdata_o, s_wdata_i[31:0]);
        chk("s_r_valid", s_r_valid_o, m_r_valid_i);
        chk("s_r_opc", s_r_opc_o, m_r_opc_i);
        if (m_r_valid_i) begin
            exp_tag = (mq.size() > 0) ? mq[0] : 4'hF;
            chk("s_r_rdata", s_r_rdata_o, {exp_tag, m_r_rdata_i});
        end
        snap_gnt   = s_gnt_o;
        snap_req   = m_req_o;
        snap_rdata = s_r_rdata_o;
        snap64_gnt = d_s_gnt;
        snap64     = d_s_rdata;
        acc = s_req_i && gnt;
        model_map(s_add_i, cov, idx);
        push_val = (s_wen_i && cov) ? mtags[idx] : 4'hF;
        @(posedge clk_i);
        if (m_r_valid_i) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else merr = 1'b1;
        end
        if (acc) mq.push_back(push_val);
        if (tag_clear_i) begin
            for (int i = 0; i < 1024; i++) mtags[i] = 4'hF;
        end else if (acc && !s_wen_i && cov) begin
            for (int b = 0; b < 4; b++)
                if (s_be_i[b]) mtags[idx][b] = s_wdata_i[32+b];
        end
        @(negedge clk_i);
    endtask

    task automatic access(input bit wen, input logic [31:0] addr,
                          input logic [3:0] be, input logic [3:0] tag);
        drive(1'b1, wen, addr, be, tag, 1'b1, mq.size() > 0, 1'b0);
        cycle();
    endtask

    task automatic drain();
        drive(1'b0, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, BASE, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] addr;
    logic [63:0] rd64;

    initial begin
        rst_ni = 1'b0;
        d_clr  = 1'b0;
        drive64(1'b0, 1'b1, BASE, 8'h00, 8'h00, 1'b1, 1'b1, 64'h0);
        drive(1'b0, 1'b1, BASE, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        model_reset();
        #2;
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_s_gnt", s_gnt_o, 1);
        chk("rst_s_r_valid", s_r_valid_o, 1);
        chk("rst_tag", s_r_rdata_o[35:32], 4'hF);
        chk("rst64_outstanding", d_out, 0);
        idle();
        drive64(1'b0, 1'b1, BASE, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Partial-byte-enable write then immediate read of the same word.
        access(1'b0, BASE + 32'h10, 4'b0101, 4'b0000);
        access(1'b1, BASE + 32'h10, 4'hF, 4'h0);
        drain();
        chk("req025_tag", snap_rdata[35:32], 4'b1010);
        chk("req025_data", snap_rdata[31:0], m_r_rdata_i);

        // Uncovered write aliases index 0 after truncation; must not land there.
        access(1'b0, 32'h1C01_0000, 4'hF, 4'h0);
        access(1'b1, BASE, 4'hF, 4'h0);
        access(1'b1, 32'h1C01_0000, 4'hF, 4'h0);
        chk("req026_idx0", snap_rdata[35:32], 4'hF);
        drain();
        chk("req026_uncov", snap_rdata[35:32], 4'hF);

        // Boundary words: last covered, first past the window, just below base.
        access(1'b0, BASE + 32'hFFC, 4'hF, 4'h0);
        access(1'b0, BASE + 32'h1000, 4'hF, 4'h0);
        access(1'b0, BASE - 32'h4, 4'hF, 4'h0);
        access(1'b1, BASE + 32'hFFC, 4'hF, 4'h0);
        access(1'b1, BASE + 32'h1000, 4'hF, 4'h0);
        chk("last_idx", snap_rdata[35:32], 4'h0);
        access(1'b1, BASE - 32'h4, 4'hF, 4'h0);
        chk("past_end", snap_rdata[35:32], 4'hF);
        drain();
        chk("below_base", snap_rdata[35:32], 4'hF);

        // FIFO full back-pressure.
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0); cycle();
        chk("req027_gnt", snap_gnt, 0);
        chk("req027_mreq", snap_req, 0);
        chk("req027_outstanding", outstanding_o, 2);
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0); cycle();
        chk("req027_pop_gnt", snap_gnt, 0);
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0); cycle();
        chk("req027_third_gnt", snap_gnt, 1);
        drain();
        drain();

        // Clear racing a write: clear wins.
        access(1'b0, BASE + 32'd20, 4'hF, 4'h0);
        drive(1'b1, 1'b0, BASE + 32'd24, 4'hF, 4'h0, 1'b1, mq.size() > 0, 1'b1);
        cycle();
        access(1'b1, BASE + 32'd20, 4'hF, 4'h0);
        access(1'b1, BASE + 32'd24, 4'hF, 4'h0);
        chk("req029_idx5", snap_rdata[35:32], 4'hF);
        drain();
        chk("req029_idx6", snap_rdata[35:32], 4'hF);

        // Spurious response with nothing pending.
        drain();
        chk("req028_tag", snap_rdata[35:32], 4'hF);
        chk("req028_err", err_o, 1);
        chk("req028_outstanding", outstanding_o, 0);

        // 64-bit instance.
        idle();
        drive64(1'b1, 1'b0, 32'h1C00_0008, 8'hF0, 8'h00, 1'b1, 1'b0, 64'h0);
        cycle();
        chk("d64_gnt", snap64_gnt, 1);
        drive64(1'b1, 1'b1, 32'h1C00_0008, 8'hFF, 8'h00, 1'b1, 1'b0, 64'h0);
        cycle();
        chk("d64_outstanding", d_out, 2);
        rd64 = {$urandom(), $urandom()};
        drive64(1'b0, 1'b1, 32'h1C00_0008, 8'h00, 8'h00, 1'b1, 1'b1, rd64);
        cycle();
        chk("d64_write_resp", snap64, {8'hFF, rd64});
        rd64 = {$urandom(), $urandom()};
        drive64(1'b0, 1'b1, 32'h1C00_0008, 8'h00, 8'h00, 1'b1, 1'b1, rd64);
        cycle();
        chk("d64_read_tag", snap64, {8'h0F, rd64});
        drive64(1'b0, 1'b1, BASE, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0);
        cycle();
        chk("d64_outstanding_end", d_out, 0);
        chk("d64_err", d_err, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0: addr = BASE + 4 * $urandom_range(0, 1023);
                1: addr = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
                2: begin
                    case ($urandom_range(0, 4))
                        0: addr = BASE + 32'hFFC;
                        1: addr = BASE + 32'h1000;
                        2: addr = BASE - 32'h4;
                        3: addr = 32'h1C01_0000 + 4 * $urandom_range(0, 7);
                        default: addr = $urandom();
                    endcase
                end
                default: addr = BASE + 4 * $urandom_range(0, 7);
            endcase
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0,
                  (mq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 39) == 0);
            cycle();
        end

        // Reset with responses pending.
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b1, BASE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0); cycle();
        idle();
        #3;
        rst_ni = 1'b0;
        #1;
        chk("midrst_outstanding", outstanding_o, 0);
        chk("midrst_err", err_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        access(1'b1, BASE + 32'h10, 4'hF, 4'h0);
        drain();
        chk("midrst_tag", snap_rdata[35:32], 4'hF);
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
